uart_dump_ctrl: RTL and testbench

Sequencer for the monitor's memory-dump commands ("r" data memory, "p" instruction memory).
- Captures start/end addresses from the command decoder's 32-bit word and walks the range one word at a time.
- Issues reads to the selected memory and streams each word as ASCII hex plus CR LF to the UART transmitter.
- Drives dump_running back to the command decoder so its dump state returns to idle when the range completes.

---
 rtl/uart_dump_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_dump_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_dump_ctrl.sv
// Memory-dump sequencer: walks a word-aligned address range, reads each word and
// streams it to the UART transmitter as eight lowercase hex characters plus CR LF.
module uart_dump_ctrl #(
    parameter int NIBBLES = 8,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] uart_data,
    input  logic        read_start_set,
    input  logic        read_end_set,
    input  logic        read_stop,
    input  logic        pgm_start_set,
    input  logic        pgm_end_set,
    input  logic        pgm_stop,
    input  logic        tx_busy,
    input  logic [31:0] rd_data,
    output logic        rd_req,
    output logic [31:0] rd_adr,
    output logic        rd_sel,
    output logic [7:0]  tx_char,
    output logic        tx_en,
    output logic        dump_running
);

    localparam int NW = $clog2(NIBBLES + 1);
    localparam logic [31:0] TOP_ADR = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE, S_RDREQ, S_RDWAIT, S_HEX, S_CR, S_LF, S_NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   start_adr_q, start_adr_d;
    logic [31:0]   end_adr_q, end_adr_d;
    logic [31:0]   cur_adr_q, cur_adr_d;
    logic          rd_sel_q, rd_sel_d;
    logic [31:0]   sh_q, sh_d;
    logic [NW-1:0] nib_q, nib_d;
    logic [1:0]    lat_q, lat_d;
    logic          guard_q, guard_d;

    logic          abort, start_set, end_set;
    logic [31:0]   in_aln;
    logic [3:0]    nib;
    logic [7:0]    hex_char;

    assign abort     = read_stop | pgm_stop;
    assign start_set = read_start_set | pgm_start_set;
    assign end_set   = read_end_set | pgm_end_set;
    assign in_aln    = {uart_data[31:2], 2'b00};
    assign nib       = sh_q[31:28];
    assign hex_char  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_adr_q <= '0;
            end_adr_q   <= '0;
            cur_adr_q   <= '0;
            rd_sel_q    <= 1'b0;
            sh_q        <= '0;
            nib_q       <= '0;
            lat_q       <= '0;
            guard_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_adr_q <= start_adr_d;
            end_adr_q   <= end_adr_d;
            cur_adr_q   <= cur_adr_d;
            rd_sel_q    <= rd_sel_d;
            sh_q        <= sh_d;
            nib_q       <= nib_d;
            lat_q       <= lat_d;
            guard_q     <= guard_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_adr_d = start_adr_q;
        end_adr_d   = end_adr_q;
        cur_adr_d   = cur_adr_q;
        rd_sel_d    = rd_sel_q;
        sh_d        = sh_q;
        nib_d       = nib_q;
        lat_d       = lat_q;
        guard_d     = guard_q;
        rd_req      = 1'b0;
        tx_en       = 1'b0;
        tx_char     = 8'h00;

        if (state_q == S_IDLE) begin
            guard_d = 1'b0;
            nib_d   = '0;
            if (start_set) start_adr_d = in_aln;
            if (end_set) begin
                end_adr_d = in_aln;
                rd_sel_d  = ~read_end_set;
                // a start latched in this same cycle must be the first address
                cur_adr_d = start_set ? in_aln : start_adr_q;
                state_d   = S_RDREQ;
            end
        end else if (abort) begin
            state_d = S_IDLE;
            guard_d = 1'b0;
        end else begin
            unique case (state_q)
                S_RDREQ: begin
                    rd_req  = 1'b1;
                    lat_d   = '0;
                    state_d = S_RDWAIT;
                end
                S_RDWAIT: begin
                    if (lat_q == 2'(RD_LAT - 1)) begin
                        sh_d    = rd_data;
                        nib_d   = '0;
                        state_d = S_HEX;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                S_HEX: begin
                    if (guard_q) begin
                        guard_d = 1'b0;
                        if (nib_q == NW'(NIBBLES)) state_d = S_CR;
                    end else if (!tx_busy) begin
                        tx_en   = 1'b1;
                        tx_char = hex_char;
                        sh_d    = {sh_q[27:0], 4'h0};
                        nib_d   = nib_q + 1'b1;
                        guard_d = 1'b1;
                    end
                end
                S_CR: begin
                    if (guard_q) begin
                        guard_d = 1'b0;
                        state_d = S_LF;
                    end else if (!tx_busy) begin
                        tx_en   = 1'b1;
                        tx_char = 8'h0d;
                        guard_d = 1'b1;
                    end
                end
                S_LF: begin
                    if (guard_q) begin
                        guard_d = 1'b0;
                        state_d = S_NEXT;
                    end else if (!tx_busy) begin
                        tx_en   = 1'b1;
                        tx_char = 8'h0a;
                        guard_d = 1'b1;
                    end
                end
                S_NEXT: begin
                    // the top-of-space check keeps cur_adr from wrapping to 0
                    if (cur_adr_q >= end_adr_q || cur_adr_q == TOP_ADR) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_adr_d = cur_adr_q + 32'd4;
                        state_d   = S_RDREQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rd_adr       = cur_adr_q;
    assign rd_sel       = rd_sel_q;
    assign dump_running = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Scoreboard bench for uart_dump_ctrl: stimulus queues expected characters and reads,
// a negedge monitor pops and compares whenever the DUT strobes tx_en or rd_req.
module tb_uart_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] uart_data = '0;
    logic        read_start_set = 1'b0, read_end_set = 1'b0, read_stop = 1'b0;
    logic        pgm_start_set = 1'b0, pgm_end_set = 1'b0, pgm_stop = 1'b0;
    logic        tx_busy = 1'b0;
    logic [31:0] rd_data = '0;
    logic        rd_req, rd_sel, tx_en, dump_running;
    logic [31:0] rd_adr;
    logic [7:0]  tx_char;

    uart_dump_ctrl #(.NIBBLES(8), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .uart_data(uart_data),
        .read_start_set(read_start_set), .read_end_set(read_end_set), .read_stop(read_stop),
        .pgm_start_set(pgm_start_set), .pgm_end_set(pgm_end_set), .pgm_stop(pgm_stop),
        .tx_busy(tx_busy), .rd_data(rd_data), .rd_req(rd_req), .rd_adr(rd_adr),
        .rd_sel(rd_sel), .tx_char(tx_char), .tx_en(tx_en), .dump_running(dump_running)
    );

    always #5 clk = ~clk;

    int          vecs = 0, errs = 0, tx_seen = 0;
    int          chk_seq = 0, chk_done = 0, busy_cnt = 0;
    bit          chk_to = 1'b0, bp_mode = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [32:0] exp_rd[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h12ab34cd;
            32'h0000_0014: return 32'hdeadbeef;
            32'h0000_0000: return 32'h00c0ffee;
            32'h0000_0020: return 32'h13579bdf;
            32'h0000_0040: return 32'h0badf00d;
            32'h0000_0100: return 32'ha5f00912;
            32'hFFFF_FFF8: return 32'hfedcba98;
            32'hFFFF_FFFC: return 32'h76543210;
            default:       return 32'h0;
        endcase
    endfunction

    // monitor: scoreboard compare, memory model, back-pressure generator
    always @(negedge clk) begin
        logic [7:0]  et;
        logic [32:0] er;
        if (tx_en) begin
            vecs++;
            tx_seen++;
            if (exp_tx.size() == 0) begin
                errs++;
                $display("FAIL tx_unexpected: got char %02h, expected no strobe", tx_char);
            end else begin
                et = exp_tx.pop_front();
                if (tx_char !== et || tx_busy !== 1'b0) begin
                    errs++;
                    $display("FAIL tx_char: got %02h (busy %0b), expected %02h (busy 0)",
                             tx_char, tx_busy, et);
                end
            end
        end
        if (rd_req) begin
            vecs++;
            if (exp_rd.size() == 0) begin
                errs++;
                $display("FAIL rd_unexpected: got sel %0b adr %08h, expected no read", rd_sel, rd_adr);
            end else begin
                er = exp_rd.pop_front();
                if ({rd_sel, rd_adr} !== er) begin
                    errs++;
                    $display("FAIL rd_req: got sel %0b adr %08h, expected sel %0b adr %08h",
                             rd_sel, rd_adr, er[32], er[31:0]);
                end
            end
            rd_data = mem(rd_adr);
        end
        if (chk_seq != chk_done) begin
            chk_done = chk_seq;
            vecs++;
            if (dump_running !== 1'b0 || rd_req !== 1'b0 || tx_en !== 1'b0 ||
                exp_tx.size() != 0 || exp_rd.size() != 0 || chk_to) begin
                errs++;
                $display("FAIL idle_check #%0d: got run %0b rd_req %0b tx_en %0b pend_tx %0d pend_rd %0d timeout %0b, expected all 0",
                         chk_seq, dump_running, rd_req, tx_en, exp_tx.size(), exp_rd.size(), chk_to);
            end
        end
        if (bp_mode && tx_en) begin
            tx_busy  = 1'b1;
            busy_cnt = 20;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
    end

    task automatic push_word(input string s, input bit sel, input logic [31:0] adr);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
        exp_tx.push_back(8'h0d);
        exp_tx.push_back(8'h0a);
        exp_rd.push_back({sel, adr});
    endtask

    task automatic cmd(input bit pgm, input logic [31:0] s, input logic [31:0] e);
        @(posedge clk); #1;
        uart_data = s;
        if (pgm) pgm_start_set = 1'b1; else read_start_set = 1'b1;
        @(posedge clk); #1;
        pgm_start_set = 1'b0; read_start_set = 1'b0;
        uart_data = e;
        if (pgm) pgm_end_set = 1'b1; else read_end_set = 1'b1;
        @(posedge clk); #1;
        pgm_end_set = 1'b0; read_end_set = 1'b0;
    endtask

    task automatic request_check();
        @(posedge clk); #1;
        chk_seq++;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_done();
        int n;
        chk_to = 1'b0;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!dump_running) break;
        end
        if (n >= 3000) chk_to = 1'b1;
        request_check();
    endtask

    initial begin
        int base, n;
        // reset state, sampled while reset is held
        repeat (2) @(posedge clk);
        #1 chk_seq++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        request_check();

        // two-word data dump
        push_word("12ab34cd", 1'b0, 32'h10);
        push_word("deadbeef", 1'b0, 32'h14);
        cmd(1'b0, 32'h10, 32'h14);
        wait_done();

        // program dump with unaligned addresses -> single word at 0
        push_word("00c0ffee", 1'b1, 32'h0);
        cmd(1'b1, 32'h3, 32'h3);
        wait_done();

        // back-pressure: busy for 20 cycles after every strobe
        bp_mode = 1'b1;
        push_word("12ab34cd", 1'b0, 32'h10);
        push_word("deadbeef", 1'b0, 32'h14);
        cmd(1'b0, 32'h10, 32'h14);
        wait_done();
        bp_mode = 1'b0;
        repeat (25) @(posedge clk);

        // abort after the third character of word 0
        exp_tx.push_back("1");
        exp_tx.push_back("2");
        exp_tx.push_back("a");
        exp_rd.push_back({1'b0, 32'h10});
        base = tx_seen;
        cmd(1'b0, 32'h10, 32'h14);
        for (n = 0; n < 200; n++) begin
            @(posedge clk); #2;
            if (tx_seen >= base + 3) break;
        end
        read_stop = 1'b1;
        @(posedge clk); #1;
        read_stop = 1'b0;
        chk_to = (n >= 200);
        chk_seq++;
        repeat (30) @(posedge clk);
        request_check();

        // a fresh sequence after the abort
        push_word("0badf00d", 1'b0, 32'h40);
        cmd(1'b0, 32'h40, 32'h40);
        wait_done();

        // inverted range -> only the start word
        push_word("a5f00912", 1'b0, 32'h100);
        cmd(1'b0, 32'h100, 32'h40);
        wait_done();

        // top of address space, no wrap to 0
        push_word("fedcba98", 1'b0, 32'hFFFF_FFF8);
        push_word("76543210", 1'b0, 32'hFFFF_FFFC);
        cmd(1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        wait_done();

        // start and end in the same cycle -> single word from that uart_data
        push_word("13579bdf", 1'b1, 32'h20);
        @(posedge clk); #1;
        uart_data = 32'h22;
        pgm_start_set = 1'b1;
        pgm_end_set = 1'b1;
        @(posedge clk); #1;
        pgm_start_set = 1'b0;
        pgm_end_set = 1'b0;
        wait_done();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
